// File: rtl/song_sequencer.sv
// song_sequencer: walks the selected song's note list in a synchronous song ROM and hands each
//    note to the note player. Optional feature macro: SONG_SEQUENCER_LOOP_EN (repeat the song
//    instead of parking in END).
// Latency: play -> new_note 3 cycles; note_done -> next new_note 4 cycles; marker -> song_done
//    registered. Backpressure: a note is held until note_done; play low pauses between notes.
// Ports: clk, reset (async, active high); MCU side play, reset_player, song, song_done;
//    ROM side rom_addr, rom_data; note player side note, duration, new_note, note_done.
`timescale 1ns/1ps
module song_sequencer #(
   parameter int SONG_W = 2,
   parameter int IDX_W  = 5,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      play,
   input  logic                      reset_player,
   input  logic [SONG_W-1:0]         song,
   output logic                      song_done,
   output logic [SONG_W+IDX_W-1:0]   rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]   rom_data,
   output logic [NOTE_W-1:0]         note,
   output logic [DUR_W-1:0]          duration,
   output logic                      new_note,
   input  logic                      note_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_END   = 3'd5;

   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   logic [2:0]              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [SONG_W-1:0]       song_reg_q, song_reg_d;
   // Set once the song select has been captured; cleared only by reset/restart so that
   // later changes of song are ignored.
   logic                    latched_q, latched_d;
   logic [NOTE_W-1:0]       note_q, note_d;
   logic [DUR_W-1:0]        dur_q, dur_d;
   logic                    new_note_q, new_note_d;
   logic                    song_done_q, song_done_d;
   logic [SONG_W+IDX_W-1:0] rom_addr_q, rom_addr_d;

   logic [NOTE_W-1:0]       rom_note;
   logic [DUR_W-1:0]        rom_dur;

   assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_data[DUR_W-1:0];

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      song_reg_d  = song_reg_q;
      latched_d   = latched_q;
      note_d      = note_q;
      dur_d       = dur_q;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;

      if (reset_player) begin
         // Restart wins over note_done, play and the end condition.
         state_d   = S_IDLE;
         idx_d     = '0;
         latched_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (play) begin
                  if (!latched_q) begin
                     song_reg_d = song;
                     latched_d  = 1'b1;
                  end
                  state_d = S_FETCH;
               end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
               if (rom_dur == '0) begin
                  state_d = S_DONE;
               end else begin
                  note_d     = rom_note;
                  dur_d      = rom_dur;
                  new_note_d = 1'b1;
                  state_d    = S_WAIT;
               end
            end
            S_WAIT: begin
               if (note_done) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
            S_DONE: begin
               song_done_d = 1'b1;
               idx_d       = '0;
`ifdef SONG_SEQUENCER_LOOP_EN
               state_d     = S_IDLE;
`else
               state_d     = S_END;
`endif
            end
            S_END: state_d = S_END;
            default: state_d = S_IDLE;
         endcase
      end

      // Address is registered from next-state values so it is stable throughout FETCH.
      rom_addr_d = {song_reg_d, idx_d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         song_reg_q  <= '0;
         latched_q   <= 1'b0;
         note_q      <= '0;
         dur_q       <= '0;
         new_note_q  <= 1'b0;
         song_done_q <= 1'b0;
         rom_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         song_reg_q  <= song_reg_d;
         latched_q   <= latched_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         new_note_q  <= new_note_d;
         song_done_q <= song_done_d;
         rom_addr_q  <= rom_addr_d;
      end
   end

   assign song_done = song_done_q;
   assign rom_addr  = rom_addr_q;
   assign note      = note_q;
   assign duration  = dur_q;
   assign new_note  = new_note_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed and randomized checks of song_sequencer against a note-list model.
// Latency: expected pulse timing derived from play/note_done events.
// Backpressure: note_done issued after a random hold per note.
`timescale 1ns/1ps
module tb_song_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic        reset_player;
   logic [1:0]  song;
   logic        song_done;
   logic [6:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note;
   logic [5:0]  duration;
   logic        new_note;
   logic        note_done;

   song_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .play         (play),
      .reset_player (reset_player),
      .song         (song),
      .song_done    (song_done),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .note         (note),
      .duration     (duration),
      .new_note     (new_note),
      .note_done    (note_done)
   );

   always #5 clk = ~clk;

   // Synchronous song ROM: {note, duration}, 4 songs x 32 entries.
   logic [11:0] rom [0:127];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int nn_cnt = 0;
   int sd_cnt = 0;
   always @(posedge clk) begin
      if (new_note === 1'b1) nn_cnt <= nn_cnt + 1;
      if (song_done === 1'b1) sd_cnt <= sd_cnt + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      note_done = 1'b0;
   endtask

   task automatic wait_nn(output int n);
      n = -1;
      for (int k = 1; k <= 40 && n < 0; k++) begin
         step();
         if (new_note === 1'b1) n = k;
      end
   endtask

   task automatic wait_sd(output int n);
      n = -1;
      for (int k = 1; k <= 40 && n < 0; k++) begin
         step();
         if (song_done === 1'b1) n = k;
      end
   endtask

   // Reference: the song is its entries up to the first zero duration, at most 32.
   int         exp_n;
   logic [5:0] exp_note [32];
   logic [5:0] exp_dur  [32];

   function automatic void build_model(input int s);
      logic [11:0] w;
      bit          stop;
      exp_n = 0;
      stop  = 0;
      for (int i = 0; i < 32; i++) begin
         w = rom[s*32 + i];
         if (w[5:0] == 6'd0) stop = 1;
         if (!stop) begin
            exp_note[exp_n] = w[11:6];
            exp_dur[exp_n]  = w[5:0];
            exp_n++;
         end
      end
   endfunction

   task automatic rand_songs();
      int m0, m2;
      m0 = $urandom_range(0, 5);
      m2 = $urandom_range(1, 12);
      for (int i = 0; i < 32; i++) begin
         rom[i]      = {6'($urandom), (i == m0) ? 6'd0 : 6'($urandom_range(1, 63))};
         rom[64 + i] = {6'($urandom), (i == m2) ? 6'd0 : 6'($urandom_range(1, 63))};
      end
   endtask

   task automatic restart(input string tag);
      reset_player = 1'b1;
      step();
      reset_player = 1'b0;
      chk({tag, " restart new_note"}, new_note, 0);
   endtask

   task automatic run_song(input int s, input bit check_end, input string tag);
      int st, c0, d;
      build_model(s);
      c0   = nn_cnt;
      song = s[1:0];
      play = 1'b1;
      for (int i = 0; i < exp_n; i++) begin
         wait_nn(st);
         chk({tag, " note lat"}, st, (i == 0) ? 3 : 4);
         chk({tag, " note"}, note, exp_note[i]);
         chk({tag, " dur"}, duration, exp_dur[i]);
         d = $urandom_range(0, 3);
         repeat (d) step();
         note_done = 1'b1;
      end
      wait_sd(st);
      chk({tag, " song_done lat"}, st, (exp_n == 0) ? 4 : ((exp_n == 32) ? 2 : 5));
      if (!check_end) play = 1'b0;
      step();
      chk({tag, " song_done width"}, song_done, 0);
      chk({tag, " note count"}, nn_cnt - c0, exp_n);
      if (check_end) begin
`ifdef SONG_SEQUENCER_LOOP_EN
         wait_nn(st);
         chk({tag, " loop lat"}, st, 2);
         chk({tag, " loop note"}, note, exp_note[0]);
         chk({tag, " loop dur"}, duration, exp_dur[0]);
`else
         c0 = nn_cnt;
         d  = sd_cnt;
         note_done = 1'b1;
         repeat (8) step();
         chk({tag, " end hold new_note"}, nn_cnt - c0, 0);
         chk({tag, " end hold song_done"}, sd_cnt - d, 0);
`endif
         play = 1'b0;
      end
      restart(tag);
   endtask

   initial begin
      int st, c0, d;
      logic [11:0] w;
      reset = 1'b1; play = 1'b0; reset_player = 1'b0; note_done = 1'b0; song = 2'd0;
      for (int i = 0; i < 128; i++) rom[i] = 12'($urandom);
      rom[32] = {6'd10, 6'd4};
      rom[33] = {6'd20, 6'd8};
      rom[34] = {6'($urandom), 6'd0};
      for (int i = 0; i < 32; i++) rom[96 + i] = {6'($urandom), 6'($urandom_range(1, 63))};
      rand_songs();

      // Reset values before any clock edge.
      #2;
      chk("reset new_note", new_note, 0);
      chk("reset song_done", song_done, 0);
      chk("reset note", note, 0);
      chk("reset duration", duration, 0);
      chk("reset rom_addr", rom_addr, 0);
      step(); step();
      reset = 1'b0;
      step();

      // Basic play-through of song 1 with end-state behaviour.
      run_song(1, 1, "basic");

      // Pause during note 0, resume at note 1.
      song = 2'd1; play = 1'b1;
      wait_nn(st);
      chk("pause first lat", st, 3);
      chk("pause first note", note, 10);
      play = 1'b0;
      repeat (2) step();
      note_done = 1'b1;
      step();
      c0 = nn_cnt;
      repeat (6) step();
      chk("pause no new_note", nn_cnt - c0, 0);
      play = 1'b1;
      wait_nn(st);
      chk("resume lat", st, 3);
      chk("resume note", note, 20);
      chk("resume dur", duration, 8);
      note_done = 1'b1;
      wait_sd(st);
      chk("resume song_done lat", st, 5);
      play = 1'b0;
      step();
      chk("resume song_done width", song_done, 0);
      restart("pause");

      // Restart has priority over note_done and play.
      song = 2'd1; play = 1'b1;
      wait_nn(st);
      chk("prio first lat", st, 3);
      reset_player = 1'b1;
      note_done    = 1'b1;
      step();
      reset_player = 1'b0;
      play         = 1'b0;
      chk("prio new_note", new_note, 0);
      chk("prio song_done", song_done, 0);
      c0 = nn_cnt;
      d  = sd_cnt;
      repeat (5) step();
      chk("prio idle new_note", nn_cnt - c0, 0);
      chk("prio idle song_done", sd_cnt - d, 0);
      song = 2'd2; play = 1'b1;
      step();
      chk("prio fetch addr", rom_addr, 64);
      wait_nn(st);
      chk("prio song2 lat", st, 2);
      w = rom[64];
      chk("prio song2 note", note, w[11:6]);
      play = 1'b0;
      note_done = 1'b1;
      step();
      restart("prio");

      // Full-length song: 32 notes, ends on the last index.
      run_song(3, 0, "full");

      // Randomized songs against the note-list model.
      for (int r = 0; r < 6; r++) begin
         rand_songs();
         run_song($urandom_range(0, 2), 0, "rand");
      end

      // Asynchronous reset mid-LOAD.
      song = 2'd1; play = 1'b1;
      step(); step();
      #2;
      reset = 1'b1;
      #1;
      chk("areset rom_addr", rom_addr, 0);
      chk("areset note", note, 0);
      chk("areset duration", duration, 0);
      chk("areset new_note", new_note, 0);
      chk("areset song_done", song_done, 0);
      play = 1'b0;
      step();
      reset = 1'b0;
      c0 = nn_cnt;
      repeat (10) step();
      chk("areset quiet", nn_cnt - c0, 0);
      play = 1'b1;
      wait_nn(st);
      chk("areset replay lat", st, 3);
      chk("areset replay note", note, 10);
      chk("areset replay dur", duration, 4);
      play = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
